stream_rr_arb: RTL
==================

# stream_rr_arb

Round-robin arbiter that shares one val/rdy output stream among `p_num_reqs` val/rdy input streams. It sits between several producers and a single consumer, for example one TestOstream sink or one memory port. It accepts at most one message per cycle from the highest-priority valid requester, buffers it in a one-entry output register, and tags it with the source index. Priority rotates so that every requester holding `val` is eventually served.

## Interface
Parameters:
- `t_msg`, default `logic[31:0]`: message type carried on every stream.
- `p_num_reqs`, default 4: number of requesters. Legal range is 2 to 16.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `req_msg`  in  `t_msg` [p_num_reqs]  per-requester message.
- `req_val`  in  [p_num_reqs]  per-requester valid.
- `req_rdy`  out  [p_num_reqs]  per-requester ready. One-hot or zero.
- `resp_msg`  out  `t_msg`  granted message.
- `resp_src`  out  `$clog2(p_num_reqs)`  index of the requester that supplied `resp_msg`.
- `resp_val`  out  1  output valid.
- `resp_rdy`  in  1  output ready.

## Operation
- State:
  - Output buffer: `full`, `msg`, `src`.
  - Priority pointer `ptr`, width `$clog2(p_num_reqs)`.
- Reset values: `full`=0, `resp_val`=0, `resp_msg`=0, `resp_src`=0, `ptr`=0, all `req_rdy`=0.
- Drain: `resp_val`=`full`. A transfer occurs when `resp_val & resp_rdy`.
- Accept condition: `!full | resp_rdy`. This allows a full buffer to drain and refill in the same cycle.
- Arbitration:
  - The winner `w` is the first index `i` with `req_val[i]`=1, scanning `ptr`, `ptr+1`, … modulo `p_num_reqs`.
  - If no requester is valid, there is no winner.
- Grant: `req_rdy[w]` = accept condition. All other `req_rdy` bits are 0.
- `req_rdy` depends combinationally on `req_val` and `resp_rdy`. A requester must not make its `val` depend on its own `rdy`.
- On input transfer (`req_val[w] & req_rdy[w]`):
  - `msg` <= `req_msg[w]`.
  - `src` <= `w`.
  - `full` <= 1.
  - `ptr` <= (`w`+1) mod `p_num_reqs`.
- On drain with no input transfer: `full` <= 0.
- `ptr` changes only on an input transfer. An idle requester set leaves `ptr` unchanged.
- Message contents are never modified.
- Order is preserved per requester. Across requesters, order follows grant order.
- `resp_msg` and `resp_src` hold stable while `resp_val`=1 and `resp_rdy`=0.

## Timing
- Latency: an input transfer in cycle N produces `resp_val`=1 in cycle N+1 (bypass disabled).
- Throughput: 1 message per cycle when `resp_rdy` is held at 1.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,N-1,0,…
- Worst-case wait for a valid requester is `p_num_reqs`-1 grants.
- Backpressure: `resp_rdy`=0 with `full`=1 forces all `req_rdy` to 0 in that cycle.
- Pointer wrap: when `w`=`p_num_reqs`-1, `ptr` becomes 0.
- Reset mid-operation: a buffered message is discarded. `ptr` returns to 0. `resp_val` is 0 in the cycle after `rst` is sampled high.
- While `rst`=1, all `req_rdy` are 0.

## Configuration
- Macro: `STREAM_RR_ARB_BYPASS_EN`.
- Defined: when `full`=0, `resp_rdy`=1 and a winner exists, the winner's message passes through in the same cycle.
  - `resp_val`=1, `resp_msg`=`req_msg[w]`, `resp_src`=`w`, all combinationally.
  - The buffer stays empty.
  - `ptr` still advances to (`w`+1) mod N.
  - Latency is 0 cycles.
  - When `resp_rdy`=0, behaviour is identical to the undefined case.
- Undefined: output is always registered and latency is 1 cycle, as described above.

## Test plan
- Reset, then single requester: `req_val`=4'b0100, `req_msg[2]`=32'hCAFE0002, `resp_rdy`=1 -> next cycle `resp_val`=1, `resp_msg`=32'hCAFE0002, `resp_src`=2. Then `ptr`=3.
- All 4 valid continuously, `resp_rdy`=1, messages 32'h10+i -> `resp_src` sequence 0,1,2,3,0,1 with one message per cycle.
- Backpressure: buffer full, `resp_rdy`=0 for 3 cycles -> all `req_rdy`=0 and `resp_msg` held. Then `resp_rdy`=1 -> drain plus a new accept in the same cycle.
- Pointer skip/wrap: `ptr`=3, `req_val`=4'b0011 -> winner 0. Next winner is 1, not 0.
- Reset with `full`=1 and `resp_rdy`=0 -> cycle after `rst`: `resp_val`=0, `ptr`=0. The held message is never delivered.
- With `STREAM_RR_ARB_BYPASS_EN`: empty buffer, `req_val[1]`=1, `req_msg[1]`=32'hBEEF, `resp_rdy`=1 -> same cycle `resp_val`=1, `resp_msg`=32'hBEEF, `resp_src`=1.

Source files
------------

// File: rtl/stream_rr_arb.sv
// Round-robin arbiter that merges p_num_reqs val/rdy streams into one tagged output stream.
// Optional STREAM_RR_ARB_BYPASS_EN passes the winner straight through when the buffer is empty.
module stream_rr_arb #(
  parameter type t_msg      = logic [31:0],
  parameter int  p_num_reqs = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  t_msg                          req_msg [p_num_reqs],
  input  logic [p_num_reqs-1:0]         req_val,
  output logic [p_num_reqs-1:0]         req_rdy,
  output t_msg                          resp_msg,
  output logic [$clog2(p_num_reqs)-1:0] resp_src,
  output logic                          resp_val,
  input  logic                          resp_rdy
);

  localparam int SW = $clog2(p_num_reqs);
  localparam logic [SW-1:0] LAST = SW'(p_num_reqs - 1);

  logic          full;
  t_msg          msg;
  logic [SW-1:0] src;
  logic [SW-1:0] ptr;

  logic          win_found;
  logic [SW-1:0] win_idx;
  logic [SW-1:0] ptr_nxt;
  logic          accept;
  logic          in_xfer;
  logic          bypass;

  function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= p_num_reqs) sum = sum - p_num_reqs;
    return SW'(sum);
  endfunction

  // First valid requester at or after ptr, scanning circularly.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      if (!win_found && req_val[wrap_idx(ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(ptr, k);
      end
    end
  end

  always_comb begin
    accept  = !rst && (!full || resp_rdy);
    in_xfer = win_found && accept;
    req_rdy = '0;
    if (in_xfer) req_rdy[win_idx] = 1'b1;
    ptr_nxt = (win_idx == LAST) ? '0 : win_idx + SW'(1);
`ifdef STREAM_RR_ARB_BYPASS_EN
    bypass  = !rst && !full && resp_rdy && win_found;
`else
    bypass  = 1'b0;
`endif
    resp_val = full || bypass;
    resp_msg = bypass ? req_msg[win_idx] : msg;
    resp_src = bypass ? win_idx : src;
  end

  // A bypassed message is consumed in flight, so the buffer stays empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      msg  <= '0;
      src  <= '0;
      ptr  <= '0;
    end else begin
      if (in_xfer) begin
        ptr <= ptr_nxt;
        if (!bypass) begin
          full <= 1'b1;
          msg  <= req_msg[win_idx];
          src  <= win_idx;
        end
      end else if (resp_rdy) begin
        full <= 1'b0;
      end
    end
  end

endmodule
